// File: rtl/spi_adc_pkg.sv
// Shared definitions for the ADC SPI link (responder and master-side capture).
package spi_adc_pkg;

  localparam int DATA_W_DEF     = 12;
  localparam int LEAD_ZEROS_DEF = 4;

  function automatic int frame_w(input int lead_zeros, input int data_w);
    return lead_zeros + data_w;
  endfunction

  typedef logic [DATA_W_DEF-1:0] sample_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/spi_adc_responder_if.sv
// SPI pins plus sample-feed and status signals of the ADC responder.
interface spi_adc_responder_if
  import spi_adc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              cs_n;
  logic              sclk;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              frame_done;
  logic              frame_abort;
  logic              underrun;
  logic [7:0]        underrun_cnt;

  modport master (
    output cs_n, sclk, sample_in, sample_valid,
    input  miso, miso_oe, sample_ready, frame_done, frame_abort, underrun, underrun_cnt
  );

  modport slave (
    input  cs_n, sclk, sample_in, sample_valid,
    output miso, miso_oe, sample_ready, frame_done, frame_abort, underrun, underrun_cnt
  );
endinterface

// File: rtl/spi_in_sync.sv
// N-flop synchronizer for an asynchronous SPI pin, with rise/fall pulses
// taken from the last two synchronized values.
module spi_in_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic rise,
  output logic fall
);
  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d_in};
    prev_d = sync_q[N-1];
  end

  assign rise = sync_q[N-1] & ~prev_q;
  assign fall = ~sync_q[N-1] & prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
endmodule

// File: rtl/spi_adc_responder.sv
// ADCS7476-style SPI responder: LEAD_ZEROS zeros then a DATA_W sample, MSB first.
// Define SPI_RESP_PATTERN_EN to replace the sample feed with an internal ramp.
//   state    | meaning
//   ST_IDLE  | cs_n high, waiting for a synced cs_n fall
//   ST_LOAD  | one cycle: pick sample, fill shift register, enable MISO
//   ST_SHIFT | advance one bit per synced sclk fall
//   ST_DONE  | all bits sent, waiting for cs_n rise
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK50,
  input  logic                MSS_RESET_N,
  spi_adc_responder_if.slave  bus
);
  localparam int FRAME_W = frame_w(LEAD_ZEROS, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);

  logic cs_rise, cs_fall, sclk_fall, sclk_rise_unused;

  spi_in_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(CLK50), .rst_n(MSS_RESET_N), .d_in(bus.cs_n), .rise(cs_rise), .fall(cs_fall)
  );
  spi_in_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(CLK50), .rst_n(MSS_RESET_N), .d_in(bus.sclk), .rise(sclk_rise_unused), .fall(sclk_fall)
  );

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic                miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic                frame_done_q, frame_done_d, frame_abort_q, frame_abort_d;
  logic                underrun_q, underrun_d;
  logic [7:0]          underrun_cnt_q, underrun_cnt_d;
  logic [DATA_W-1:0]   load_src;
  logic                load_fresh;
  logic                in_load;

  assign in_load = (state_q == ST_LOAD);

`ifdef SPI_RESP_PATTERN_EN
  logic [DATA_W-1:0] ramp_q, ramp_d;

  assign load_src         = ramp_q;
  assign load_fresh       = 1'b1;
  assign bus.sample_ready = 1'b0;

  always_comb ramp_d = in_load ? ramp_q + 1'b1 : ramp_q;

  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) ramp_q <= '0;
    else              ramp_q <= ramp_d;
  end
`else
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              ready, accept;

  // Consume and refill in the same LOAD cycle: the write wins.
  assign ready            = !hold_full_q || in_load;
  assign accept           = bus.sample_valid && ready;
  assign bus.sample_ready = ready;
  assign load_src         = hold_full_q ? hold_q : last_q;
  assign load_fresh       = hold_full_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (in_load) hold_full_d = 1'b0;
    if (accept) begin
      hold_d      = bus.sample_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bitcnt_d       = bitcnt_q;
    miso_d         = miso_q;
    miso_oe_d      = miso_oe_q;
    last_d         = last_q;
    frame_done_d   = 1'b0;
    frame_abort_d  = 1'b0;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d   = {{LEAD_ZEROS{1'b0}}, load_src};
        last_d    = load_src;
        bitcnt_d  = BIT_LAST;
        miso_d    = shreg_d[FRAME_W-1];
        miso_oe_d = 1'b1;
        if (!load_fresh) begin
          underrun_d = 1'b1;
          if (underrun_cnt_q != 8'hFF) underrun_cnt_d = underrun_cnt_q + 8'd1;
        end
        if (cs_rise) begin
          frame_abort_d = 1'b1;
          miso_oe_d     = 1'b0;
          miso_d        = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          frame_abort_d = 1'b1;
          miso_oe_d     = 1'b0;
          miso_d        = 1'b0;
          state_d       = ST_IDLE;
        end else if (sclk_fall) begin
          if (bitcnt_q != '0) begin
            shreg_d  = shreg_q << 1;
            miso_d   = shreg_q[FRAME_W-2];
            bitcnt_d = bitcnt_q - 1'b1;
          end else begin
            frame_done_d = 1'b1;
            miso_d       = 1'b0;
            state_d      = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (cs_rise) begin
          miso_oe_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      bitcnt_q       <= '0;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
      last_q         <= '0;
      frame_done_q   <= 1'b0;
      frame_abort_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bitcnt_q       <= bitcnt_d;
      miso_q         <= miso_d;
      miso_oe_q      <= miso_oe_d;
      last_q         <= last_d;
      frame_done_q   <= frame_done_d;
      frame_abort_q  <= frame_abort_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign bus.miso         = miso_q;
  assign bus.miso_oe      = miso_oe_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_abort  = frame_abort_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = underrun_cnt_q;
endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: frame table plus abort, back-to-back
// feed and async-reset sequences. Honours SPI_RESP_PATTERN_EN.
module tb_spi_adc_responder;
  import spi_adc_pkg::*;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_adc_responder_if #(.DATA_W(12)) bus();

  spi_adc_responder #(.DATA_W(12), .LEAD_ZEROS(4), .SYNC_STAGES(SYNC)) dut (
    .CLK50(clk), .MSS_RESET_N(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_abort  = 0;
  int n_ur     = 0;

  always @(negedge clk) begin
    if (bus.frame_done)  n_done++;
    if (bus.frame_abort) n_abort++;
    if (bus.underrun)    n_ur++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_partial(input int n, output logic [15:0] got);
    got = '0;
    @(negedge clk) bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      got = {got[14:0], bus.miso};
      bus.sclk = 1'b1;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, output logic [15:0] got);
    run_partial(16, got);
    check({tag, "_oe_active"}, bus.miso_oe, 1);
    check({tag, "_miso_done"}, bus.miso, 0);
    bus.cs_n = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check({tag, "_oe_off"}, bus.miso_oe, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic push_sample(input logic [11:0] v);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = v;
    for (int k = 0; k < 50; k++) begin
      if (bus.sample_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check("push_accept", ok, 1);
  endtask

  typedef struct {
    logic        load;
    logic [11:0] smp;
    logic [15:0] exp_frame;
    int          exp_ur;
    logic [7:0]  exp_cnt;
  } vec_t;

`ifdef SPI_RESP_PATTERN_EN
  localparam int NV = 3;
`else
  localparam int NV = 6;
`endif
  vec_t vecs[NV];

  logic [15:0] got, got1, got2;
  int d0, a0, u0;
  logic acc;

  initial begin
`ifdef SPI_RESP_PATTERN_EN
    vecs[0] = '{1'b0, 12'h000, 16'h0000, 0, 8'd0};
    vecs[1] = '{1'b0, 12'h000, 16'h0001, 0, 8'd0};
    vecs[2] = '{1'b0, 12'h000, 16'h0002, 0, 8'd0};
`else
    vecs[0] = '{1'b1, 12'hA5C, 16'h0A5C, 0, 8'd0};
    vecs[1] = '{1'b0, 12'h000, 16'h0A5C, 1, 8'd1};
    vecs[2] = '{1'b1, 12'h3FF, 16'h03FF, 0, 8'd1};
    vecs[3] = '{1'b1, 12'h000, 16'h0000, 0, 8'd1};
    vecs[4] = '{1'b0, 12'h000, 16'h0000, 1, 8'd2};
    vecs[5] = '{1'b1, 12'hFFF, 16'h0FFF, 0, 8'd2};
`endif

    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", bus.miso, 0);
    check("rst_oe", bus.miso_oe, 0);
`ifdef SPI_RESP_PATTERN_EN
    check("rst_ready", bus.sample_ready, 0);
`else
    check("rst_ready", bus.sample_ready, 1);
`endif
    check("rst_cnt", bus.underrun_cnt, 0);
    check("rst_pulses", {bus.frame_done, bus.frame_abort, bus.underrun}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].load) push_sample(vecs[v].smp);
      d0 = n_done;
      u0 = n_ur;
      run_frame($sformatf("vec%0d", v), got);
      check($sformatf("vec%0d_frame", v), got, vecs[v].exp_frame);
      check($sformatf("vec%0d_done", v), n_done - d0, 1);
      check($sformatf("vec%0d_underrun", v), n_ur - u0, vecs[v].exp_ur);
      check($sformatf("vec%0d_cnt", v), bus.underrun_cnt, vecs[v].exp_cnt);
`ifdef SPI_RESP_PATTERN_EN
      check($sformatf("vec%0d_ready", v), bus.sample_ready, 0);
`endif
    end

    // Abort after 7 sclk falls; the consumed sample is gone.
`ifndef SPI_RESP_PATTERN_EN
    push_sample(12'h123);
`endif
    a0 = n_abort;
    d0 = n_done;
    run_partial(7, got);
    check("abort_bits", got, 0);
    bus.cs_n = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check("abort_oe_off", bus.miso_oe, 0);
    repeat (4) @(negedge clk);
    check("abort_pulse", n_abort - a0, 1);
    check("abort_no_done", n_done - d0, 0);
`ifdef SPI_RESP_PATTERN_EN
    u0 = n_ur;
    run_frame("abort_next", got);
    check("abort_next_frame", got, 16'h0004);
    check("pattern_no_underrun", n_ur - u0, 0);
`else
    push_sample(12'h456);
    u0 = n_ur;
    run_frame("abort_next", got);
    check("abort_next_frame", got, 16'h0456);
    check("abort_next_ur", n_ur - u0, 0);

    // Back-to-back feed: 0x002 is taken in frame 1's LOAD cycle.
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'h001;
    @(negedge clk);
    check("b2b_ready_low", bus.sample_ready, 0);
    bus.sample_in = 12'h002;
    @(negedge clk);
    check("b2b_ready_held", bus.sample_ready, 0);
    acc = 1'b0;
    fork
      run_frame("b2b_f1", got1);
      begin
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          if (bus.sample_ready) begin
            acc = 1'b1;
            @(negedge clk);
            bus.sample_valid = 1'b0;
            break;
          end
        end
        bus.sample_valid = 1'b0;
      end
    join
    check("b2b_accept_in_load", acc, 1);
    check("b2b_ready_full2", bus.sample_ready, 0);
    check("b2b_frame1", got1, 16'h0001);
    u0 = n_ur;
    run_frame("b2b_f2", got2);
    check("b2b_frame2", got2, 16'h0002);
    check("b2b_no_ur", n_ur - u0, 0);
    check("b2b_ready_empty", bus.sample_ready, 1);

    // Async reset in the middle of a frame.
    push_sample(12'hFFF);
    run_partial(5, got);
    check("rst_mid_miso_pre", bus.miso, 1);
    check("rst_mid_oe_pre", bus.miso_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_miso", bus.miso, 0);
    check("rst_mid_oe", bus.miso_oe, 0);
    check("rst_mid_cnt", bus.underrun_cnt, 0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    u0 = n_ur;
    run_frame("post_rst", got);
    check("post_rst_frame", got, 16'h0000);
    check("post_rst_ur", n_ur - u0, 1);
    check("post_rst_cnt", bus.underrun_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end
endmodule
